// File: rtl/if_queue.sv
// if_queue: instruction fetch queue between the memory controller and decode.
// It issues word-aligned fetches, captures each returned word on mem_ok and
// reorders its bytes into instruction order. The (pc, inst) pair is buffered
// in a DEPTH-entry FIFO that decode drains over a valid/ready handshake.
// A redirect flushes the queue and discards any in-flight fetch.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   mem_req/mem_addr  outstanding fetch request and its byte address
//   mem_ok/mem_word   one-cycle completion pulse and the assembled word
//   redirect/_pc      flush and restart fetching at redirect_pc (word aligned)
//   inst_valid/ready  decode handshake on the queue head
//   inst_o/pc_o       head instruction and PC (zero when the queue is empty)
module if_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter bit          SWAP     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ok,
   input  logic [31:0] mem_word,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [31:0]      fpc;
   logic [31:0]      fpc_nxt;
   logic             req_nxt;
   logic [31:0]      addr_nxt;
   logic             push;
   logic             pop;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic [31:0] pc_mem   [DEPTH];
   logic [31:0] inst_mem [DEPTH];

   // Memory words arrive first-byte-in-MSB; instructions are little-endian.
   function automatic logic [31:0] order_bytes(input logic [31:0] w);
      logic [31:0] r;
      r = SWAP ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
      return r;
   endfunction

   // Head decode from registered queue state only.
   assign inst_valid = (count != '0);
   assign inst_o     = inst_valid ? inst_mem[rd_ptr] : 32'h0;
   assign pc_o       = inst_valid ? pc_mem[rd_ptr]   : 32'h0;

   // Next-state, request and queue-control decode.
   always_comb begin
      state_nxt = state;
      req_nxt   = mem_req;
      addr_nxt  = mem_addr;
      fpc_nxt   = fpc;
      push      = 1'b0;
      pop       = inst_valid & inst_ready & ~redirect;

      case (state)
         ST_IDLE: begin
            // Issue only if a slot remains for the word after this cycle's pop.
            if (!redirect && ((count - CNT_W'(pop)) < CNT_W'(DEPTH))) begin
               state_nxt = ST_REQ;
               req_nxt   = 1'b1;
               addr_nxt  = fpc;
            end
         end
         ST_REQ: begin
            if (mem_ok) begin
               state_nxt = ST_IDLE;
               req_nxt   = 1'b0;
               if (!redirect) begin
                  push    = 1'b1;
                  fpc_nxt = fpc + 32'd4;
               end
            end else if (redirect) begin
               // Keep the request up so the controller can finish the bus cycle.
               state_nxt = ST_DISCARD;
            end
         end
         ST_DISCARD: begin
            // The cancelled word is consumed exactly once, even under redirect.
            if (mem_ok) begin
               state_nxt = ST_IDLE;
               req_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            req_nxt   = 1'b0;
         end
      endcase

      if (redirect) fpc_nxt = {redirect_pc[31:2], 2'b00};
   end

   // State, request and queue bookkeeping registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         mem_req  <= 1'b0;
         mem_addr <= RESET_PC;
         fpc      <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         state    <= state_nxt;
         mem_req  <= req_nxt;
         mem_addr <= addr_nxt;
         fpc      <= fpc_nxt;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Queue storage; contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         pc_mem[wr_ptr]   <= fpc;
         inst_mem[wr_ptr] <= order_bytes(mem_word);
      end
   end

endmodule

// File: tb/tb_if_queue.sv
// tb_if_queue: directed scenarios plus randomized traffic for if_queue,
// checked against a queue-based reference model of the fetch stream.
module tb_if_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ok;
   logic [31:0] mem_word;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_o;
   logic [31:0] pc_o;

   if_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .SWAP(1'b1)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ok(mem_ok), .mem_word(mem_word),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_o(inst_o), .pc_o(pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   int n_tests = 0;
   int n_fail  = 0;

   ent_t        q[$];
   logic [31:0] exp_fpc = RESET_PC;
   bit          live = 1'b0;
   bit          prev_req = 1'b0;
   bit          req_rose = 1'b0;
   bit          force_ok = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   int          wait_cnt = 0;
   int          lat = 1;
   int          n_ok = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Memory image: the two documented words at 0x0/0x4, a hash elsewhere.
   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h0) return 32'h1300_0000;
      if (a == 32'h4) return 32'h9300_0100;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] bswap(input logic [31:0] w);
      logic [31:0] r;
      r = {<<8{w}};
      return r;
   endfunction

   // Apply the effect of the cycle that just ended to the reference stream.
   task automatic model_edge();
      ent_t e;
      bit   do_pop;
      if (rst) begin
         q.delete();
         exp_fpc = RESET_PC;
         live    = 1'b0;
      end else begin
         if (mem_ok) check("ok_in_req", 32'(prev_req), 32'd1);
         do_pop = (q.size() != 0) && inst_ready && !redirect;
         if (redirect) begin
            q.delete();
            exp_fpc = {redirect_pc[31:2], 2'b00};
            live    = 1'b0;
         end else begin
            if (do_pop) void'(q.pop_front());
            if (mem_ok && live) begin
               e.pc   = exp_fpc;
               e.inst = bswap(mem_word);
               q.push_back(e);
               exp_fpc = exp_fpc + 32'd4;
               check("q_bound", 32'(q.size() <= DEPTH), 32'd1);
            end
         end
         if (mem_ok) live = 1'b0;
      end
   endtask

   task automatic model_check();
      ent_t h;
      h = '0;
      if (q.size() != 0) h = q[0];
      check("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
      check("pc_o", pc_o, h.pc);
      check("inst_o", inst_o, h.inst);
      req_rose = mem_req && !prev_req;
      if (req_rose) begin
         check("req_addr", mem_addr, exp_fpc);
         live = 1'b1;
      end
      if (mem_req && prev_req) check("addr_stable", mem_addr, prev_addr);
      prev_req  = mem_req;
      prev_addr = mem_addr;
   endtask

   // Memory controller: answers each request after lat extra cycles.
   task automatic respond();
      mem_ok = 1'b0;
      if (force_ok) begin
         mem_ok   = 1'b1;
         mem_word = 32'hDEAD_BEEF;
         force_ok = 1'b0;
      end else if (mem_req) begin
         if (wait_cnt >= lat) begin
            mem_ok   = 1'b1;
            mem_word = memf(mem_addr);
            wait_cnt = 0;
            n_ok++;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      model_check();
      respond();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int k;
      int rises;
      int ok0;

      rst = 1'b1; mem_ok = 1'b0; mem_word = 32'h0; redirect = 1'b0;
      redirect_pc = 32'h0; inst_ready = 1'b1;

      // Reset state and the documented two-word stream.
      tick(); tick();
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_addr", mem_addr, RESET_PC);
      check("rst_inst", inst_o, 32'h0);
      rst = 1'b0;
      tick();
      check("first_req", 32'(mem_req), 32'd1);
      check("first_addr", mem_addr, 32'h0);
      tick(); tick();
      check("s_req_low", 32'(mem_req), 32'd0);
      check("s_pc0", pc_o, 32'h0);
      check("s_inst0", inst_o, 32'h0000_0013);
      tick();
      check("s_addr4", mem_addr, 32'h4);
      tick(); tick();
      check("s_pc1", pc_o, 32'h4);
      check("s_inst1", inst_o, 32'h0001_0093);
      tick();
      check("s_addr8", mem_addr, 32'h8);

      // Backpressure: queue fills to DEPTH, then one pop reopens fetch.
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      inst_ready = 1'b0; lat = 1; ok0 = n_ok;
      repeat (20) tick();
      check("bp_accepted", 32'(n_ok - ok0), 32'(DEPTH));
      check("bp_head_pc", pc_o, 32'h0);
      repeat (4) begin
         tick();
         check("bp_hold_req", 32'(mem_req), 32'd0);
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check("bp_req_after_pop", 32'(mem_req), 32'd1);
      check("bp_addr", mem_addr, 32'h10);
      check("bp_next_head", pc_o, 32'h4);

      // Redirect while a fetch at 0x8 is outstanding.
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      inst_ready = 1'b1; lat = 1; found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         tick();
         if (req_rose && mem_addr == 32'h8) found = 1'b1;
      end
      check("rd_found_req8", 32'(found), 32'd1);
      lat = 4; redirect = 1'b1; redirect_pc = 32'h103;
      tick();
      redirect = 1'b0;
      check("rd_keep_req", 32'(mem_req), 32'd1);
      check("rd_keep_addr", mem_addr, 32'h8);
      check("rd_flushed", 32'(inst_valid), 32'd0);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         tick();
         if (mem_ok) found = 1'b1;
      end
      check("rd_ok_seen", 32'(found), 32'd1);
      lat = 1;
      tick();
      check("rd_drop_req", 32'(mem_req), 32'd0);
      check("rd_drop_valid", 32'(inst_valid), 32'd0);
      tick();
      check("rd_new_req", 32'(mem_req), 32'd1);
      check("rd_new_addr", mem_addr, 32'h100);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         tick();
         if (inst_valid) found = 1'b1;
      end
      check("rd_first_pc", pc_o, 32'h100);
      check("rd_first_inst", inst_o, bswap(memf(32'h100)));

      // Redirect coincident with mem_ok and a pop.
      inst_ready = 1'b0; found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         tick();
         if (req_rose && inst_valid) found = 1'b1;
      end
      check("co_found", 32'(found), 32'd1);
      tick();
      check("co_ok_now", 32'(mem_ok), 32'd1);
      redirect = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1;
      tick();
      redirect = 1'b0;
      check("co_empty", 32'(inst_valid), 32'd0);
      check("co_idle", 32'(mem_req), 32'd0);
      tick();
      check("co_req", 32'(mem_req), 32'd1);
      check("co_addr", mem_addr, 32'h200);

      // Address wrap and FIFO pointer wrap over 3*DEPTH entries.
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      k = 0; rises = 0;
      for (int c = 0; c < 400 && k < 3 * DEPTH; c++) begin
         inst_ready = ($urandom_range(0, 1) == 1);
         if (!mem_req) lat = $urandom_range(1, 3);
         if (inst_valid && inst_ready) begin
            check("wrap_pc", pc_o, 32'hFFFF_FFFC + 32'(4 * k));
            k++;
         end
         tick();
         if (req_rose && rises < 2) begin
            check("wrap_fetch", mem_addr, (rises == 0) ? 32'hFFFF_FFFC : 32'h0);
            rises++;
         end
      end
      check("wrap_pops", 32'(k), 32'(3 * DEPTH));

      // Reset while fetching with three entries queued.
      rst = 1'b1; tick(); rst = 1'b0;
      inst_ready = 1'b0; lat = 1; found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         tick();
         if (req_rose && q.size() == 3) found = 1'b1;
      end
      check("rs_found", 32'(found), 32'd1);
      check("rs_count3", 32'(inst_valid), 32'd1);
      lat = 1000; rst = 1'b1;
      tick();
      check("rs_req", 32'(mem_req), 32'd0);
      check("rs_valid", 32'(inst_valid), 32'd0);
      check("rs_addr", mem_addr, RESET_PC);
      force_ok = 1'b1;
      tick(); tick();
      check("rs_ok_ignored", 32'(inst_valid), 32'd0);
      rst = 1'b0; lat = 1;
      tick();
      check("rs_restart", 32'(mem_req), 32'd1);
      check("rs_restart_addr", mem_addr, RESET_PC);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         inst_ready  = ($urandom_range(0, 9) < 7);
         redirect    = ($urandom_range(0, 99) < 3);
         redirect_pc = $urandom;
         rst         = ($urandom_range(0, 499) == 0);
         if (!mem_req) lat = $urandom_range(1, 4);
         tick();
      end
      rst = 1'b0; redirect = 1'b0; inst_ready = 1'b1;
      repeat (10) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_queue.md
# if_queue

Instruction fetch queue between the byte-assembling memory controller and the decoder. It issues word-aligned fetch addresses to the memory controller, accepts each completed 32-bit word on the controller's one-cycle ok pulse, and reorders the bytes into RISC-V little-endian instruction order. Each instruction and its PC are buffered in a small FIFO and presented to decode over a valid/ready handshake. A branch/jump redirect flushes the queue and discards any in-flight fetch.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0: first fetch address after reset.
- SWAP, 1: 1 means inst = {w[7:0],w[15:8],w[23:16],w[31:24]} (memory word assembled first-byte-in-MSB); 0 means pass-through.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mem_req  out  1  fetch request outstanding (level)
- mem_addr  out  32  byte address of the outstanding fetch; stable while mem_req=1
- mem_ok  in  1  one-cycle pulse: mem_word valid for the current request
- mem_word  in  32  assembled word from the memory controller
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] are forced to 0
- inst_valid  out  1  queue head valid (count != 0)
- inst_ready  in  1  decoder accepts the head this cycle
- inst_o  out  32  head instruction (after SWAP); 0 when inst_valid=0
- pc_o  out  32  head PC; 0 when inst_valid=0

## Operation
- State: fpc (next fetch PC), FIFO storage, rd/wr pointers, count (0..DEPTH), FSM {IDLE, REQ, DISCARD}.
- IDLE: if count + (push this cycle) − (pop this cycle) < DEPTH, go to REQ with mem_req=1 and mem_addr=fpc on the next cycle. One slot is reserved per request, so the queue never overflows.
- REQ: wait for mem_ok. On mem_ok, push {fpc, swap(mem_word)}, set fpc += 4 (32-bit wrap), mem_req←0, and go to IDLE.
- DISCARD: wait for mem_ok of the cancelled request. The word is dropped, mem_req←0, and the FSM goes to IDLE. fpc is not advanced.
- Pop: inst_valid & inst_ready advances rd and decrements count. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority, any state):
  - count←0 and pointers←0.
  - fpc←{redirect_pc[31:2],2'b00}.
  - Any push or pop in that cycle is ignored.
  - In REQ without mem_ok that cycle: go to DISCARD, keeping mem_req=1 and mem_addr unchanged so the controller completes the bus transaction.
  - In REQ with mem_ok that cycle: drop the word and go to IDLE.
  - In IDLE or DISCARD: go to IDLE or stay in DISCARD respectively.
- Redirect during DISCARD updates fpc again; the pending word is still dropped exactly once.
- mem_ok while in IDLE is ignored; this is a protocol error and the bench asserts it never occurs.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_o=0, pc_o=0; fpc=RESET_PC, count=0, FSM=IDLE.
- The first mem_req rises in the 1st cycle after rst deasserts.
- mem_req, mem_addr, and the FSM are registered. inst_o, pc_o, and inst_valid are decoded from registered queue state with no combinational path from inputs.
- The earliest mem_ok is the cycle after mem_req rises.
- A pushed word is visible at inst_valid/inst_o the cycle after mem_ok.
- Minimum spacing between requests: mem_req low for exactly 1 cycle after each mem_ok, when space is available.
- Full queue (count=DEPTH with no slot reserved): FSM holds IDLE. A pop in cycle t allows mem_req in cycle t+1.
- Redirect at cycle t: inst_valid=0 at t+1. A new request at fpc issues by t+2 from IDLE, or two cycles after the discarded mem_ok.

## Test plan
- Reset then stream: memory returns words 0x13000000, 0x93000100 at addresses 0x0, 0x4 with inst_ready=1 -> mem_addr sequence 0x0, 0x4, 0x8; outputs (pc_o, inst_o) = (0x0, 0x00000013), then (0x4, 0x00010093).
- Backpressure: inst_ready=0 with DEPTH=4 -> exactly 4 words accepted, mem_req stays 0 while count=4. Raise inst_ready for 1 cycle -> one pop, and mem_req rises the next cycle at address 0x10.
- Redirect mid-fetch: redirect to 0x103 while in REQ at 0x8, with mem_ok 3 cycles later -> that word is dropped, inst_valid=0, next mem_addr=0x100, and the first output pc_o=0x100.
- Redirect coincident with mem_ok and with a pop -> no push, no pop, queue empty next cycle, FSM in IDLE, next request at the redirect PC.
- Wrap-around: RESET_PC=0xFFFFFFFC -> fetches 0xFFFFFFFC then 0x0; FIFO pointers wrap after 3×DEPTH pushes with the order preserved.
- Reset asserted while in REQ with count=3 -> next cycle mem_req=0, inst_valid=0, mem_addr=RESET_PC, and a later mem_ok is ignored.
